// File: rtl/banked_mem_pkg.sv
// banked_mem_pkg
// Shared types and helpers for the byte-banked data memory controller.
//   size_e     : access size encoding carried on reqSize
//   state_e    : controller state (zero-fill, then normal service)
//   lane_mask  : byte lanes touched by an access of a given size and offset
package banked_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_WORD  = 2'b10,
        SZ_DWORD = 2'b11
    } size_e;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Up to eight lanes; callers truncate to their own lane count.
    function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] offset);
        logic [7:0] base;
        case (size)
            SZ_BYTE:  base = 8'h01;
            SZ_HALF:  base = 8'h03;
            SZ_WORD:  base = 8'h0F;
            SZ_DWORD: base = 8'hFF;
            default:  base = 8'h00;
        endcase
        return base << offset;
    endfunction

endpackage

// File: rtl/mem_lane.sv
// mem_lane
// One DEPTH x 8 byte bank with synchronous write and synchronous read.
//   clk, rst_n : clock, async active-low reset (read register only)
//   we, wdata  : write enable and byte written at addr on the clock edge
//   re         : capture mem[addr] into the read register on the clock edge
//   addr       : word index into the bank
//   rdata      : registered read byte, held while re is low
module mem_lane #(
    parameter int DEPTH = 1024,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic             re,
    input  logic [IDX_W-1:0] addr,
    input  logic [7:0]       wdata,
    output logic [7:0]       rdata
);

    logic [7:0] mem_r [DEPTH];
    logic [7:0] rd_r;

    // Storage array write; contents are only ever cleared by the zero-fill sequence.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    // Read register; holds its value between reads so responses stay stable under backpressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_r <= 8'h00;
        end else if (re) begin
            rd_r <= mem_r[addr];
        end
    end

    assign rdata = rd_r;

endmodule

// File: rtl/banked_mem_ctrl.sv
// banked_mem_ctrl
// Byte-banked data memory with sub-word load/store, a valid/ready request
// channel, a one-cycle registered response with backpressure, and a
// zero-fill of every word after reset.
//   clk, rst_n        : clock, async active-low reset
//   reqValid/reqReady : request handshake (accepted when both high)
//   reqWrite          : 1 store, 0 load
//   reqAddr           : byte address
//   reqSize           : 00 byte, 01 half, 10 word, 11 dword
//   reqSigned         : sign-extend sub-word loads
//   reqWdata          : store data, LSB-aligned
//   respValid/respReady : response handshake
//   respData          : load result, LSB-aligned and extended; 0 for stores/errors
//   respErr           : misaligned, out of range, or illegal size
//   initDone          : zero-fill complete
module banked_mem_ctrl
    import banked_mem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reqValid,
    output logic              reqReady,
    input  logic              reqWrite,
    input  logic [ADDR_W-1:0] reqAddr,
    input  logic [1:0]        reqSize,
    input  logic              reqSigned,
    input  logic [DATA_W-1:0] reqWdata,
    output logic              respValid,
    input  logic              respReady,
    output logic [DATA_W-1:0] respData,
    output logic              respErr,
    output logic              initDone
);

    localparam int NUM_LANES = DATA_W / 8;
    localparam int OFF_W     = $clog2(NUM_LANES);
    localparam int IDX_W     = $clog2(DEPTH);

    state_e             state_r;
    logic [IDX_W-1:0]   init_cnt_r;
    logic               init_done_r;
    logic               resp_valid_r;
    logic               resp_err_r;
    logic               resp_load_r;
    logic               resp_signed_r;
    logic [1:0]         resp_size_r;
    logic [OFF_W-1:0]   resp_off_r;

    logic [OFF_W-1:0]     off_s;
    logic [IDX_W-1:0]     idx_s;
    logic                 oor_s;
    logic                 misalign_s;
    logic                 err_s;
    logic                 accept_s;
    logic                 wr_s;
    logic                 rd_s;
    logic [NUM_LANES-1:0] be_s;
    logic [DATA_W-1:0]    wdata_sh_s;

    logic [NUM_LANES-1:0] lane_we_s;
    logic                 lane_re_s;
    logic [IDX_W-1:0]     lane_addr_s;
    logic [DATA_W-1:0]    lane_wdata_s;
    logic [DATA_W-1:0]    lane_q_s;

    logic [DATA_W-1:0]    rd_sh_s;
    logic [6:0]           bits_s;
    logic                 sign_s;
    logic [DATA_W-1:0]    low_mask_s;
    logic [DATA_W-1:0]    ext_s;

    // Address split: lane offset, word index, and everything above must be zero.
    assign off_s = reqAddr[OFF_W-1:0];
    assign idx_s = reqAddr[OFF_W +: IDX_W];
    assign oor_s = (reqAddr >> (OFF_W + IDX_W)) != {ADDR_W{1'b0}};

    // Natural-alignment and size legality check.
    always_comb begin
        misalign_s = 1'b0;
        case (reqSize)
            SZ_BYTE:  misalign_s = 1'b0;
            SZ_HALF:  misalign_s = off_s[0];
            SZ_WORD:  misalign_s = (off_s[1:0] != 2'b00);
            SZ_DWORD: begin
                if (DATA_W == 32) begin
                    misalign_s = 1'b1;
                end else begin
                    misalign_s = (off_s != {OFF_W{1'b0}});
                end
            end
            default:  misalign_s = 1'b1;
        endcase
    end

    assign err_s      = misalign_s | oor_s;
    // A new request may enter whenever the response slot is empty or being drained this cycle.
    assign reqReady   = (state_r == ST_RUN) && (!resp_valid_r || respReady);
    assign accept_s   = reqValid && reqReady;
    assign wr_s       = accept_s && reqWrite && !err_s;
    assign rd_s       = accept_s && !reqWrite && !err_s;
    assign be_s       = NUM_LANES'(lane_mask(reqSize, 3'(off_s)));
    assign wdata_sh_s = reqWdata << {off_s, 3'b000};

    // Bank port steering: zero-fill owns the banks during INIT, requests afterwards.
    always_comb begin
        lane_we_s    = {NUM_LANES{1'b0}};
        lane_re_s    = 1'b0;
        lane_addr_s  = idx_s;
        lane_wdata_s = wdata_sh_s;
        if (state_r == ST_INIT) begin
            lane_we_s    = {NUM_LANES{1'b1}};
            lane_addr_s  = init_cnt_r;
            lane_wdata_s = {DATA_W{1'b0}};
        end else begin
            lane_we_s = wr_s ? be_s : {NUM_LANES{1'b0}};
            lane_re_s = rd_s;
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        mem_lane #(
            .DEPTH (DEPTH),
            .IDX_W (IDX_W)
        ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (lane_we_s[l]),
            .re    (lane_re_s),
            .addr  (lane_addr_s),
            .wdata (lane_wdata_s[l*8 +: 8]),
            .rdata (lane_q_s[l*8 +: 8])
        );
    end

    // Response formatting: align the captured lanes to the LSB and extend above the access size.
    always_comb begin
        rd_sh_s = lane_q_s >> {resp_off_r, 3'b000};
        bits_s  = 7'd8;
        sign_s  = 1'b0;
        case (resp_size_r)
            SZ_BYTE:  begin bits_s = 7'd8;  sign_s = rd_sh_s[7];        end
            SZ_HALF:  begin bits_s = 7'd16; sign_s = rd_sh_s[15];       end
            SZ_WORD:  begin bits_s = 7'd32; sign_s = rd_sh_s[31];       end
            SZ_DWORD: begin bits_s = 7'd64; sign_s = rd_sh_s[DATA_W-1]; end
            default:  begin bits_s = 7'd8;  sign_s = 1'b0;              end
        endcase
        // A shift by the full width yields zero, so a full-width access keeps every bit and ignores the sign.
        low_mask_s = ~({DATA_W{1'b1}} << bits_s);
        ext_s      = (rd_sh_s & low_mask_s) | ({DATA_W{resp_signed_r & sign_s}} & ~low_mask_s);
    end

    assign respData  = resp_load_r ? ext_s : {DATA_W{1'b0}};
    assign respValid = resp_valid_r;
    assign respErr   = resp_err_r;
    assign initDone  = init_done_r;

    // Controller FSM: zero-fill sequencing, then response slot management.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_INIT;
            init_cnt_r    <= {IDX_W{1'b0}};
            init_done_r   <= 1'b0;
            resp_valid_r  <= 1'b0;
            resp_err_r    <= 1'b0;
            resp_load_r   <= 1'b0;
            resp_signed_r <= 1'b0;
            resp_size_r   <= 2'b00;
            resp_off_r    <= {OFF_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (init_cnt_r == IDX_W'(DEPTH - 1)) begin
                        state_r     <= ST_RUN;
                        init_done_r <= 1'b1;
                    end else begin
                        init_cnt_r <= init_cnt_r + IDX_W'(1);
                    end
                end
                ST_RUN: begin
                    if (accept_s) begin
                        resp_valid_r  <= 1'b1;
                        resp_err_r    <= err_s;
                        resp_load_r   <= rd_s;
                        resp_signed_r <= reqSigned;
                        resp_size_r   <= reqSize;
                        resp_off_r    <= off_s;
                    end else if (respReady) begin
                        resp_valid_r <= 1'b0;
                        resp_err_r   <= 1'b0;
                        resp_load_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_banked_mem_ctrl.sv
// tb_banked_mem_ctrl
// Directed bench for banked_mem_ctrl (32-bit data, 1024 words per bank).
module tb_banked_mem_ctrl;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 32;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] D = 2'b11;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              reqValid;
    logic              reqReady;
    logic              reqWrite;
    logic [ADDR_W-1:0] reqAddr;
    logic [1:0]        reqSize;
    logic              reqSigned;
    logic [DATA_W-1:0] reqWdata;
    logic              respValid;
    logic              respReady;
    logic [DATA_W-1:0] respData;
    logic              respErr;
    logic              initDone;

    int vectors = 0;
    int errors  = 0;

    always #5 clk = ~clk;

    banked_mem_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .reqWrite  (reqWrite),
        .reqAddr   (reqAddr),
        .reqSize   (reqSize),
        .reqSigned (reqSigned),
        .reqWdata  (reqWdata),
        .respValid (respValid),
        .respReady (respReady),
        .respData  (respData),
        .respErr   (respErr),
        .initDone  (initDone)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One request with respReady held high; response is checked 1 cycle after accept.
    task automatic xact(input string tag, input logic wr, input logic [ADDR_W-1:0] addr,
                        input logic [1:0] sz, input logic sg, input logic [DATA_W-1:0] wd,
                        input logic [DATA_W-1:0] expData, input logic expErr);
        reqValid  = 1'b1;
        reqWrite  = wr;
        reqAddr   = addr;
        reqSize   = sz;
        reqSigned = sg;
        reqWdata  = wd;
        respReady = 1'b1;
        check({tag, ".rdy"}, 32'(reqReady), 32'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        check({tag, ".valid"}, 32'(respValid), 32'd1);
        check({tag, ".data"}, respData, expData);
        check({tag, ".err"}, 32'(respErr), 32'(expErr));
    endtask

    // Counts clock edges after reset release until the controller starts accepting requests.
    task automatic wait_init(input string tag);
        int cnt = 0;
        while (reqReady !== 1'b1 && cnt < 3 * DEPTH) begin
            @(posedge clk); #1;
            cnt++;
            if (cnt == DEPTH - 1) begin
                check({tag, ".notdone"}, 32'(initDone), 32'd0);
            end
        end
        check({tag, ".cycles"}, 32'(cnt), 32'(DEPTH));
        check({tag, ".done"}, 32'(initDone), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n     = 1'b0;
        reqValid  = 1'b1;
        reqWrite  = 1'b0;
        reqAddr   = 32'h0;
        reqSize   = W;
        reqSigned = 1'b0;
        reqWdata  = 32'h0;
        respReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst.reqReady", 32'(reqReady), 32'd0);
        check("rst.respValid", 32'(respValid), 32'd0);
        check("rst.respData", respData, 32'h0);
        check("rst.respErr", 32'(respErr), 32'd0);
        check("rst.initDone", 32'(initDone), 32'd0);

        // Release with a word load of 0x0 already pending.
        rst_n = 1'b1;
        wait_init("init1");
        @(posedge clk); #1;
        reqValid = 1'b0;
        check("zero.valid", 32'(respValid), 32'd1);
        check("zero.data", respData, 32'h0000_0000);
        check("zero.err", 32'(respErr), 32'd0);

        // Sub-word loads and sign extension.
        xact("st_w0",     1'b1, 32'h0, W, 1'b0, 32'hDEAD_BEEF, 32'h0, 1'b0);
        xact("ld_b3_s",   1'b0, 32'h3, B, 1'b1, 32'h0, 32'hFFFF_FFDE, 1'b0);
        xact("ld_b3_u",   1'b0, 32'h3, B, 1'b0, 32'h0, 32'h0000_00DE, 1'b0);
        xact("ld_h0_s",   1'b0, 32'h0, H, 1'b1, 32'h0, 32'hFFFF_BEEF, 1'b0);
        xact("ld_h2_u",   1'b0, 32'h2, H, 1'b0, 32'h0, 32'h0000_DEAD, 1'b0);
        xact("ld_w0_s",   1'b0, 32'h0, W, 1'b1, 32'h0, 32'hDEAD_BEEF, 1'b0);

        // Byte merge into an existing word.
        xact("st_w4",     1'b1, 32'h4, W, 1'b0, 32'h1234_5678, 32'h0, 1'b0);
        xact("st_b5",     1'b1, 32'h5, B, 1'b0, 32'h0000_005A, 32'h0, 1'b0);
        xact("ld_w4",     1'b0, 32'h4, W, 1'b0, 32'h0, 32'h1234_5A78, 1'b0);

        // Error cases; none may change memory.
        xact("err_st_w2", 1'b1, 32'h2, W, 1'b0, 32'h1111_1111, 32'h0, 1'b1);
        xact("err_ld_h1", 1'b0, 32'h1, H, 1'b1, 32'h0, 32'h0, 1'b1);
        xact("err_ld_oor",1'b0, 32'h1000, W, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("err_st_oor",1'b1, 32'h1000, W, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("err_st_hi", 1'b1, 32'h8000_0004, W, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("err_dword", 1'b0, 32'h0, D, 1'b0, 32'h0, 32'h0, 1'b1);
        xact("reread_w0", 1'b0, 32'h0, W, 1'b0, 32'h0, 32'hDEAD_BEEF, 1'b0);
        xact("reread_w4", 1'b0, 32'h4, W, 1'b0, 32'h0, 32'h1234_5A78, 1'b0);

        // Backpressure: hold the response for 3 cycles with a second load queued.
        reqValid  = 1'b1;
        reqWrite  = 1'b0;
        reqAddr   = 32'h4;
        reqSize   = W;
        reqSigned = 1'b0;
        respReady = 1'b0;
        @(posedge clk); #1;
        reqAddr = 32'h0;
        check("bp.valid0", 32'(respValid), 32'd1);
        check("bp.data0", respData, 32'h1234_5A78);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check($sformatf("bp.valid%0d", i + 1), 32'(respValid), 32'd1);
            check($sformatf("bp.data%0d", i + 1), respData, 32'h1234_5A78);
            check($sformatf("bp.ready%0d", i + 1), 32'(reqReady), 32'd0);
        end
        respReady = 1'b1;
        #1;
        check("bp.release_ready", 32'(reqReady), 32'd1);
        @(posedge clk); #1;
        reqValid = 1'b0;
        check("bp.next_valid", 32'(respValid), 32'd1);
        check("bp.next_data", respData, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        check("bp.drop_valid", 32'(respValid), 32'd0);
        check("bp.drop_data", respData, 32'h0);

        // Re-enter INIT, then abort it at cycle 100 and restart.
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check("init.mid_done", 32'(initDone), 32'd0);
        check("init.mid_ready", 32'(reqReady), 32'd0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst2.initDone", 32'(initDone), 32'd0);
        check("rst2.respValid", 32'(respValid), 32'd0);
        rst_n = 1'b1;
        wait_init("init2");
        xact("refill_w0", 1'b0, 32'h0, W, 1'b0, 32'h0, 32'h0, 1'b0);
        xact("refill_w4", 1'b0, 32'h4, W, 1'b0, 32'h0, 32'h0, 1'b0);

        // Back-to-back store then load of the same word.
        xact("st_w8",     1'b1, 32'h8, W, 1'b0, 32'hCAFE_F00D, 32'h0, 1'b0);
        xact("ld_w8",     1'b0, 32'h8, W, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
        xact("ld_b8_s",   1'b0, 32'h8, B, 1'b1, 32'h0, 32'h0000_000D, 1'b0);
        xact("ld_ha_s",   1'b0, 32'hA, H, 1'b1, 32'h0, 32'hFFFF_CAFE, 1'b0);
        xact("ld_b9_s",   1'b0, 32'h9, B, 1'b1, 32'h0, 32'hFFFF_FFF0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
